// File: rtl/dmem_arbiter_if.sv
// Data-memory bus between the two masters, the arbiter and the memory.
// The arbiter takes the slave view; masters and memory take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_stall;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_stall;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_stall, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_stall, m1_rvalid, m1_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_stall, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_stall, m1_rvalid, m1_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: sticky ownership with a burst cap,
// a locked mode for the loader (master 1) and a lock watchdog.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_BURST    = 8,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    bus,
    output logic             owner,
    output logic             lock_err
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);
    localparam logic [LW-1:0] LLAST = LW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1,
        LOCK1
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [LW-1:0]     lock_q, lock_d;
    logic              owner_q, owner_d;
    logic              err_q, err_d;
    logic              block_q, block_d;
    logic              rv0_q, rv0_d;
    logic              rv1_q, rv1_d;
    logic [DATA_W-1:0] rd0_q, rd0_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;

    logic g0_raw, g1_raw;
    logic gnt0, gnt1;
    logic cap, lock_eff, fire;

    // Grant decision from current state and live requests
    always_comb begin
        g0_raw   = 1'b0;
        g1_raw   = 1'b0;
        cap      = (burst_q >= BMAX);
        lock_eff = bus.m1_lock & ~block_q;
        fire     = (state_q == LOCK1) && (lock_q == LLAST);
        case (state_q)
            IDLE: begin
                g0_raw = bus.m0_req;
                g1_raw = ~bus.m0_req & bus.m1_req;
            end
            OWN0: begin
                g0_raw = bus.m0_req & (~bus.m1_req | ~cap);
                g1_raw = ~g0_raw & bus.m1_req;
            end
            OWN1: begin
                g1_raw = bus.m1_req & (~bus.m0_req | ~cap);
                g0_raw = ~g1_raw & bus.m0_req;
            end
            LOCK1: begin
                g1_raw = bus.m1_req & bus.m1_lock;
            end
            default: begin
                g0_raw = 1'b0;
                g1_raw = 1'b0;
            end
        endcase
    end

    // Strobes are held off while reset is low so no write can slip out
    assign gnt0 = g0_raw & reset;
    assign gnt1 = g1_raw & reset;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        err_d   = err_q;
        block_d = block_q;

        rv0_d = gnt0 & ~bus.m0_we;
        rv1_d = gnt1 & ~bus.m1_we;
        rd0_d = rv0_d ? bus.mem_rdata : rd0_q;
        rd1_d = rv1_d ? bus.mem_rdata : rd1_q;

        if (fire) begin
            block_d = 1'b1;
        end else if (~bus.m1_lock) begin
            block_d = 1'b0;
        end

        if (gnt0 | gnt1) begin
            owner_d = gnt1;
            if ((state_q == IDLE) || (gnt1 != owner_q)) begin
                burst_d = BW'(1);
            end else if (~cap) begin
                burst_d = burst_q + BW'(1);
            end
        end else begin
            burst_d = '0;
        end

        lock_d = (state_q == LOCK1) ? lock_q + LW'(1) : '0;

        if (gnt0) begin
            state_d = OWN0;
        end else if (gnt1) begin
            state_d = lock_eff ? LOCK1 : OWN1;
        end else if (state_q == LOCK1) begin
            state_d = OWN1;
        end else begin
            state_d = IDLE;
        end

        if (fire) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            burst_q <= '0;
            lock_q  <= '0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            block_q <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            block_q <= block_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_stall  = bus.m0_req & ~gnt0 & reset;
    assign bus.m1_stall  = bus.m1_req & ~gnt1 & reset;
    assign bus.m0_rvalid = rv0_q;
    assign bus.m1_rvalid = rv1_q;
    assign bus.m0_rdata  = rd0_q;
    assign bus.m1_rdata  = rd1_q;

    assign bus.mem_addr  = gnt0 ? bus.m0_addr :
                           gnt1 ? bus.m1_addr : '0;
    assign bus.mem_wdata = gnt0 ? bus.m0_wdata :
                           gnt1 ? bus.m1_wdata : '0;
    assign bus.mem_write = (gnt0 & bus.m0_we) | (gnt1 & bus.m1_we);
    assign bus.mem_read  = (gnt0 & ~bus.m0_we) | (gnt1 & ~bus.m1_we);

    assign owner    = owner_q;
    assign lock_err = err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random
// traffic compared every cycle against a behavioural ownership model.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 8;
    localparam int LT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic owner;
    logic lock_err;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW),
        .MAX_BURST(MB), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus.slave),
        .owner(owner),
        .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    // Memory: 256 words plus an LED register at the MMIO address
    logic [31:0] mem [256];
    logic [31:0] led;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
            led <= '0;
        end else if (bus.mem_write) begin
            if (bus.mem_addr == 32'h4000000C) led <= bus.mem_wdata;
            else mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who is holding the bus and how
    logic md_busy = 0, md_lock = 0, md_last = 0;
    logic md_err = 0, md_blk = 0;
    logic md_pv0 = 0, md_pv1 = 0;
    logic [31:0] md_rd0 = 0, md_rd1 = 0;
    int md_run = 0, md_age = 0;

    always @(negedge clk) begin : cmp
        logic e0, e1, lk, cap, fire;
        logic [31:0] ea, ew;
        if (!rst_n) begin
            chk("rst_strb", {bus.m0_gnt, bus.m1_gnt,
                 bus.mem_read, bus.mem_write}, 0);
            chk("rst_stall", {bus.m0_stall, bus.m1_stall}, 0);
            chk("rst_rv", {bus.m0_rvalid, bus.m1_rvalid}, 0);
            chk("rst_rd0", bus.m0_rdata, 0);
            chk("rst_rd1", bus.m1_rdata, 0);
            chk("rst_addr", bus.mem_addr, 0);
            chk("rst_own", {owner, lock_err}, 0);
            md_busy = 0; md_lock = 0; md_last = 0;
            md_err = 0; md_blk = 0; md_pv0 = 0; md_pv1 = 0;
            md_rd0 = 0; md_rd1 = 0; md_run = 0; md_age = 0;
        end else begin
            lk  = bus.m1_lock && !md_blk;
            cap = md_run >= MB;
            if (md_lock) begin
                e0 = 0;
                e1 = bus.m1_req && bus.m1_lock;
            end else if (!md_busy) begin
                e0 = bus.m0_req;
                e1 = !bus.m0_req && bus.m1_req;
            end else if (!md_last) begin
                e0 = bus.m0_req && (!bus.m1_req || !cap);
                e1 = !e0 && bus.m1_req;
            end else begin
                e1 = bus.m1_req && (!bus.m0_req || !cap);
                e0 = !e1 && bus.m0_req;
            end
            ea = e0 ? bus.m0_addr : e1 ? bus.m1_addr : 0;
            ew = e0 ? bus.m0_wdata : e1 ? bus.m1_wdata : 0;
            chk("gnt0", bus.m0_gnt, e0);
            chk("gnt1", bus.m1_gnt, e1);
            chk("stall0", bus.m0_stall, bus.m0_req && !e0);
            chk("stall1", bus.m1_stall, bus.m1_req && !e1);
            chk("maddr", bus.mem_addr, ea);
            chk("mwdata", bus.mem_wdata, ew);
            chk("mread", bus.mem_read,
                (e0 && !bus.m0_we) || (e1 && !bus.m1_we));
            chk("mwrite", bus.mem_write,
                (e0 && bus.m0_we) || (e1 && bus.m1_we));
            chk("rvalid0", bus.m0_rvalid, md_pv0);
            chk("rvalid1", bus.m1_rvalid, md_pv1);
            chk("rdata0", bus.m0_rdata, md_rd0);
            chk("rdata1", bus.m1_rdata, md_rd1);
            chk("owner", owner, md_last);
            chk("lock_err", lock_err, md_err);

            fire = md_lock && (md_age == LT - 1);
            md_pv0 = e0 && !bus.m0_we;
            md_pv1 = e1 && !bus.m1_we;
            if (md_pv0) md_rd0 = mem[bus.m0_addr[9:2]];
            if (md_pv1) md_rd1 = mem[bus.m1_addr[9:2]];
            if (e0 || e1) begin
                if (e1 != md_last || (!md_busy && !md_lock)) md_run = 1;
                else if (md_run < MB) md_run = md_run + 1;
                md_last = e1;
            end else begin
                md_run = 0;
            end
            if (fire) begin
                md_err = 1; md_blk = 1; md_busy = 0; md_lock = 0;
            end else begin
                if (!bus.m1_lock) md_blk = 0;
                if (e0) begin
                    md_busy = 1; md_lock = 0;
                end else if (e1 && lk) begin
                    md_age = md_lock ? md_age + 1 : 0;
                    md_busy = 1; md_lock = 1;
                end else if (e1) begin
                    md_busy = 1; md_lock = 0;
                end else begin
                    md_busy = md_lock; md_lock = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_on();
        step();
        rst_n = 0;
    endtask

    task automatic rst_off(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("rst_nowr", bus.mem_write, 0);
        end
        step();
        rst_n = 1;
    endtask

    task automatic idle_in();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        bus.m1_lock = 0;
    endtask

    initial begin
        int nw;
        int lrun;
        idle_in();
        rst_n = 0;
        pl_en = 1;
        for (int i = 0; i < 256; i++) begin
            pl_addr = 8'(i);
            pl_data = (i == 0) ? 32'h64636261 : $urandom;
            step();
        end
        pl_en = 0;

        // Reset with both masters writing
        rst_on();
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h10;
        bus.m0_wdata = 32'h11;
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h20;
        bus.m1_wdata = 32'h22;
        rst_off(3);
        @(negedge clk);
        chk("first_g0", bus.m0_gnt, 1);
        chk("first_g1", bus.m1_gnt, 0);
        chk("first_st1", bus.m1_stall, 1);

        // Single read of preloaded word 0
        rst_on();
        idle_in();
        bus.m0_req = 1;
        rst_off(2);
        @(negedge clk);
        chk("rd_strobe", bus.mem_read, 1);
        step();
        bus.m0_req = 0;
        @(negedge clk);
        chk("rd_valid", bus.m0_rvalid, 1);
        chk("rd_data", bus.m0_rdata, 32'h64636261);

        // Both masters streaming: 8/8 alternation
        rst_on();
        bus.m0_req = 1; bus.m0_addr = 32'h4;
        bus.m1_req = 1; bus.m1_addr = 32'h8;
        rst_off(2);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("bst_g0", bus.m0_gnt, ((i / 8) % 2) == 0);
            chk("bst_st0", bus.m0_stall, ((i / 8) % 2) == 1);
            step();
        end

        // Locked MMIO write sequence from the loader
        rst_on();
        idle_in();
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_lock = 1;
        bus.m1_addr = 32'h4000000C; bus.m1_wdata = 32'hA5;
        rst_off(2);
        nw = 0;
        @(negedge clk);
        chk("lk_g1", bus.m1_gnt, 1);
        chk("lk_addr", bus.mem_addr, 32'h4000000C);
        chk("lk_wd", bus.mem_wdata, 32'hA5);
        nw += int'(bus.mem_write);
        step();
        bus.m0_req = 1;
        for (int k = 1; k < 4; k++) begin
            bus.m1_addr = 32'h40 + 32'(4 * k);
            bus.m1_wdata = 32'(k);
            @(negedge clk);
            chk("lk_m0off", bus.m0_gnt, 0);
            chk("lk_m1on", bus.m1_gnt, 1);
            if (k == 1) chk("lk_led", led, 32'hA5);
            nw += int'(bus.mem_write);
            step();
        end
        bus.m1_lock = 0; bus.m1_req = 0;
        @(negedge clk);
        chk("lk_drop", bus.m0_gnt, 0);
        nw += int'(bus.mem_write);
        step();
        @(negedge clk);
        chk("lk_m0", bus.m0_gnt, 1);
        chk("lk_nw", nw, 4);

        // Lock watchdog
        rst_on();
        idle_in();
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_lock = 1;
        bus.m1_addr = 32'h80; bus.m1_wdata = 32'h5A;
        rst_off(2);
        @(negedge clk);
        step();
        bus.m0_req = 1;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            chk("to_m0off", bus.m0_gnt, 0);
            chk("to_noerr", lock_err, 0);
            step();
        end
        @(negedge clk);
        chk("to_err", lock_err, 1);
        chk("to_m0g", bus.m0_gnt, 1);
        repeat (4) step();
        bus.m0_req = 0;
        repeat (2) step();
        bus.m1_req = 0; bus.m0_req = 1;
        @(negedge clk);
        chk("rf_m0", bus.m0_gnt, 1);
        step();
        bus.m0_req = 0; bus.m1_lock = 0;
        step();
        bus.m1_req = 1; bus.m1_lock = 1;
        step();
        bus.m1_req = 0; bus.m0_req = 1;
        @(negedge clk);
        chk("rl_m0", bus.m0_gnt, 0);
        chk("rl_err", lock_err, 1);
        step();
        idle_in();

        // Reset landing on a granted read
        rst_on();
        bus.m0_req = 1; bus.m0_addr = 32'h0;
        rst_off(2);
        step();
        @(negedge clk);
        chk("ar_pre_rv", bus.m0_rvalid, 1);
        chk("ar_pre_rd", bus.mem_read, 1);
        #2;
        rst_n = 0;
        #1;
        chk("ar_gnt", bus.m0_gnt, 0);
        chk("ar_mrd", bus.mem_read, 0);
        chk("ar_rv", bus.m0_rvalid, 0);
        chk("ar_rdata", bus.m0_rdata, 0);
        step();
        chk("ar_rv2", bus.m0_rvalid, 0);
        rst_off(2);

        // Random traffic
        lrun = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if ($urandom_range(0, 599) == 0) rst_n = 0;
            else rst_n = 1;
            bus.m0_req = $urandom_range(0, 3) != 0;
            bus.m1_req = $urandom_range(0, 3) != 0;
            bus.m0_we = $urandom_range(0, 1) == 1;
            bus.m1_we = $urandom_range(0, 1) == 1;
            bus.m0_addr = {22'h0, 8'($urandom), 2'b00};
            bus.m1_addr = ($urandom_range(0, 7) == 0) ?
                          32'h40000010 : {22'h0, 8'($urandom), 2'b00};
            bus.m0_wdata = $urandom;
            bus.m1_wdata = $urandom;
            if (lrun > 0) begin
                lrun--;
                bus.m1_lock = 1;
            end else if ($urandom_range(0, 19) == 0) begin
                lrun = $urandom_range(1, 80);
                bus.m1_lock = 1;
            end else begin
                bus.m1_lock = 0;
            end
        end
        step();
        rst_n = 1;
        idle_in();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter for the single-port data memory and its MMIO window (LED at 0x4000000C, BCD/anode at 0x40000010).
- Master 0 is the pipeline MEM stage; master 1 is the program/data loader (DMA).
- Drives the memory's address, write-data and read/write strobes. Applies sticky ownership with a burst cap, a locked-sequence mode for master 1, and a lock watchdog.
- Provides a stall signal to the pipeline hazard unit.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_BURST, 8, max consecutive grants to one owner while the other master waits (>=1).
- LOCK_TIMEOUT, 64, max cycles master 1 may hold a lock before it is forcibly broken.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 access request, level.
- m0_we  in  1  master 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  master 0 byte address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 access performed this cycle.
- m0_stall  out  1  m0_req & ~m0_gnt.
- m0_rvalid  out  1  master 0 read data valid, 1 cycle after a granted read.
- m0_rdata  out  DATA_W  master 0 read data, registered.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: as for master 0.
- m1_lock  in  1  master 1 requests exclusive ownership.
- mem_addr  out  ADDR_W  to memory Address.
- mem_wdata  out  DATA_W  to memory Write_data.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_rdata  in  DATA_W  from memory Read_data (combinational).
- owner  out  1  last granted master.
- lock_err  out  1  sticky; set when the lock watchdog fires.

Behaviour:
- States: IDLE, OWN0, OWN1, LOCK1. Registers: state, burst_cnt ($clog2(MAX_BURST+1) bits), lock_cnt ($clog2(LOCK_TIMEOUT+1) bits), rvalid/rdata per master, owner, lock_err.
- Grant is combinational from the current state and the requests; at most one gnt per cycle.
  - IDLE: m0_req -> grant 0; else m1_req -> grant 1. Master 0 has priority.
  - OWN0: if m0_req and (~m1_req or burst_cnt < MAX_BURST) -> grant 0; else if m1_req -> grant 1; else none.
  - OWN1: symmetric to OWN0, and additionally subject to the lock rules below.
  - LOCK1: only master 1 may be granted (when m1_req); m0_gnt = 0.
- Next state:
  - grant 0 -> OWN0.
  - grant 1 with m1_lock=1 -> LOCK1.
  - grant 1 with m1_lock=0 -> OWN1.
  - No grant from OWNx -> IDLE.
  - LOCK1 -> OWN1 when m1_lock=0 (no grant that cycle) or m1_req=0.
  - LOCK1 -> IDLE when lock_cnt reaches LOCK_TIMEOUT-1; lock_err <= 1 at the same edge.
- Counters:
  - burst_cnt <= 1 when the grant changes master; increments on a repeat grant, saturating at MAX_BURST; <= 0 in IDLE.
  - lock_cnt <= 0 on entry to LOCK1; increments every cycle in LOCK1 regardless of m1_req.
- Memory drive:
  - mem_addr/mem_wdata = the granted master's fields; 0 when there is no grant.
  - mem_write = gnt & we; mem_read = gnt & ~we.
  - Writes to MMIO addresses pass unchanged; the memory decodes them.
- Read return: at the edge after a granted read, mX_rdata <= mem_rdata and mX_rvalid <= 1 for exactly 1 cycle. Writes produce no rvalid. mX_rdata holds its value otherwise.
- Watchdog lockout: after lock_err fires, m1_lock is ignored until m1_lock has been sampled low for 1 cycle.
- Reset (async, reset=0, also mid-access):
  - state=IDLE, all gnt/rvalid/mem_read/mem_write = 0, rdata = 0, counters = 0, owner = 0, lock_err = 0.
  - All strobes are forced to 0 while reset is low, so no memory write occurs.
- Simultaneous first requests: master 0 wins.
- Requests that drop while waiting are not remembered.

Test Plan:
- Reset with both requests high -> mem_write=0 throughout. First cycle after release: m0_gnt=1, m1_gnt=0, m1 stalled.
- m0 reads addr 0x0 with memory preloaded 0x64636261 -> mem_read=1 in the grant cycle; next cycle m0_rvalid=1, m0_rdata=0x64636261.
- m0 and m1 both requesting continuously, MAX_BURST=8 -> grant pattern is 8 cycles m0 then 8 cycles m1, repeating; m0_stall high exactly during the m1 windows.
- m1 write with m1_lock=1 to 0x4000000C, data 0xA5, then 3 more locked writes while m0_req is high -> m0_gnt=0 for all 4; mem_write pulses 4 times; m0 is granted in the cycle after m1_lock drops.
- m1_lock held for 70 cycles, LOCK_TIMEOUT=64 -> lock_err=1 after cycle 64, state IDLE, m0 granted next. Relocking is refused until m1_lock has been sampled low for 1 cycle.
- Reset asserted during a granted read -> the rvalid pulse is suppressed and all outputs read 0 asynchronously.
